// File: rtl/eq_pkg.sv
`default_nettype none
// ============================================================================
// Package : eq_pkg
// Brief   : Shared widths, I2S frame timing points and sample type.
// Rev     : 1.0 - initial release
// ============================================================================
package eq_pkg;

    localparam int DATA_W      = 16;
    localparam int FRAME_CNT_W = 10;

    localparam logic [4:0] MSB_SLOT = 5'd1;
    localparam logic [4:0] LSB_SLOT = 5'd16;

    localparam logic [FRAME_CNT_W-1:0] TX_LOAD_L = 10'd15;
    localparam logic [FRAME_CNT_W-1:0] TX_LOAD_R = 10'd527;
    localparam logic [FRAME_CNT_W-1:0] RX_DONE_L = 10'd263;
    localparam logic [FRAME_CNT_W-1:0] RX_DONE_R = 10'd775;

    typedef logic signed [DATA_W-1:0] sample_t;

    // Bit slot within the current half-frame (16 clk per slot).
    function automatic logic [4:0] slot_of(input logic [FRAME_CNT_W-1:0] cnt);
        return cnt[8:4];
    endfunction

endpackage
`default_nettype wire

// File: rtl/codec_intf_if.sv
`default_nettype none
// ============================================================================
// Interface : codec_intf_if
// Brief     : I2S pins plus parallel sample ports between EQ datapath and CODEC.
// Rev       : 1.0 - initial release
// ============================================================================
interface codec_intf_if;
    import eq_pkg::*;

    logic    SDout;
    sample_t lft_out;
    sample_t rht_out;
    logic    MCLK;
    logic    SCLK;
    logic    LRCLK;
    logic    SDin;
    logic    RSTn;
    sample_t lft_in;
    sample_t rht_in;
    logic    valid;

    modport master (
        input  SDout, lft_out, rht_out,
        output MCLK, SCLK, LRCLK, SDin, RSTn, lft_in, rht_in, valid
    );

    modport slave (
        output SDout, lft_out, rht_out,
        input  MCLK, SCLK, LRCLK, SDin, RSTn, lft_in, rht_in, valid
    );
endinterface
`default_nettype wire

// File: rtl/i2s_shift.sv
`default_nettype none
// ============================================================================
// Module : i2s_shift
// Brief  : Sample-wide MSB-first shift register with parallel load (load wins).
// Rev    : 1.0 - initial release
// ============================================================================
module i2s_shift
    import eq_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    i_load,
    input  logic    i_shift,
    input  sample_t i_din,
    input  logic    i_ser,
    output sample_t o_word,
    output logic    o_msb
);

    sample_t r_sh_q;
    sample_t w_sh_d;

    always_comb begin
        w_sh_d = r_sh_q;
        if (i_load) begin
            w_sh_d = i_din;
        end else if (i_shift) begin
            w_sh_d = {r_sh_q[DATA_W-2:0], i_ser};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh_q <= '0;
        end else begin
            r_sh_q <= w_sh_d;
        end
    end

    // o_word is the post-edge value so a capture on the final shift edge sees the full word.
    assign o_word = w_sh_d;
    assign o_msb  = r_sh_q[DATA_W-1];

endmodule
`default_nettype wire

// File: rtl/codec_intf.sv
`default_nettype none
// ============================================================================
// Module : codec_intf
// Brief  : I2S master for the CS4272: clock generation, SDout capture, SDin drive.
// Rev    : 1.0 - initial release
// ============================================================================
module codec_intf
    import eq_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    codec_intf_if.master codec_bus
);

    logic [FRAME_CNT_W-1:0] r_cnt_q,   w_cnt_d;
    logic                   r_rstn_q,  w_rstn_d;
    logic [1:0]             r_frame_q, w_frame_d;
    sample_t                r_hold_q,  w_hold_d;
    sample_t                r_lft_q,   w_lft_d;
    sample_t                r_rht_q,   w_rht_d;
    logic                   r_valid_q, w_valid_d;

    logic [4:0] w_slot;
    logic       w_wrap;
    logic       w_rx_shift;
    logic       w_tx_load;
    logic       w_tx_shift;
    sample_t    w_tx_din;
    sample_t    w_rx_word;
    sample_t    w_tx_word;
    logic       w_rx_msb;
    logic       w_tx_msb;
    logic       w_unused;

    assign w_slot     = slot_of(r_cnt_q);
    assign w_wrap     = (r_cnt_q == '1);
    assign w_rx_shift = (r_cnt_q[3:0] == 4'd7) && (w_slot >= MSB_SLOT) && (w_slot <= LSB_SLOT);
    assign w_tx_load  = (r_cnt_q == TX_LOAD_L) || (r_cnt_q == TX_LOAD_R);
    assign w_tx_shift = (r_cnt_q[3:0] == 4'hF);
    assign w_tx_din   = (r_cnt_q == TX_LOAD_L) ? codec_bus.lft_out : codec_bus.rht_out;

    i2s_shift u_rx_shift (
        .clk     (clk),
        .rst     (rst),
        .i_load  (1'b0),
        .i_shift (w_rx_shift),
        .i_din   ('0),
        .i_ser   (codec_bus.SDout),
        .o_word  (w_rx_word),
        .o_msb   (w_rx_msb)
    );

    // Shifting zeros in leaves SDin low once the 16 data bits are out.
    i2s_shift u_tx_shift (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_tx_load),
        .i_shift (w_tx_shift),
        .i_din   (w_tx_din),
        .i_ser   (1'b0),
        .o_word  (w_tx_word),
        .o_msb   (w_tx_msb)
    );

    assign w_unused = ^{w_rx_msb, w_tx_word};

    always_comb begin
        w_cnt_d   = r_cnt_q + FRAME_CNT_W'(1);
        w_rstn_d  = r_rstn_q | w_wrap;
        w_frame_d = r_frame_q;
        w_hold_d  = r_hold_q;
        w_lft_d   = r_lft_q;
        w_rht_d   = r_rht_q;
        w_valid_d = 1'b0;

        // Frame count starts only once the CODEC is out of reset; first frame is discarded.
        if (w_wrap && r_rstn_q && (r_frame_q != 2'd3)) begin
            w_frame_d = r_frame_q + 2'd1;
        end

        if (r_cnt_q == RX_DONE_L) begin
            w_hold_d = w_rx_word;
        end

        if ((r_cnt_q == RX_DONE_R) && (r_frame_q != 2'd0)) begin
            w_valid_d = 1'b1;
            w_lft_d   = r_hold_q;
            w_rht_d   = w_rx_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_q   <= '0;
            r_rstn_q  <= 1'b0;
            r_frame_q <= 2'd0;
            r_hold_q  <= '0;
            r_lft_q   <= '0;
            r_rht_q   <= '0;
            r_valid_q <= 1'b0;
        end else begin
            r_cnt_q   <= w_cnt_d;
            r_rstn_q  <= w_rstn_d;
            r_frame_q <= w_frame_d;
            r_hold_q  <= w_hold_d;
            r_lft_q   <= w_lft_d;
            r_rht_q   <= w_rht_d;
            r_valid_q <= w_valid_d;
        end
    end

    assign codec_bus.MCLK   = r_cnt_q[1];
    assign codec_bus.SCLK   = r_cnt_q[3];
    assign codec_bus.LRCLK  = r_cnt_q[9];
    assign codec_bus.SDin   = w_tx_msb;
    assign codec_bus.RSTn   = r_rstn_q;
    assign codec_bus.lft_in = r_lft_q;
    assign codec_bus.rht_in = r_rht_q;
    assign codec_bus.valid  = r_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_codec_intf.sv
`default_nettype none
// ============================================================================
// Module : tb_codec_intf
// Brief  : Directed self-checking bench for codec_intf with a CS4272 serial model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_codec_intf;
    import eq_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    codec_intf_if bus ();

    codec_intf dut (
        .clk       (clk),
        .rst       (rst),
        .codec_bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n_valid  = 0;

    // Edges since reset release; low 10 bits are the expected frame position.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    logic        loopback = 1'b0;
    logic [15:0] m_l = 16'hA5C3;
    logic [15:0] m_r = 16'h8001;
    int          mc;
    int          mk;
    logic [15:0] mw;

    // CODEC ADC model: I2S, MSB in slot 1, changes after each edge.
    initial begin
        bus.SDout = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (loopback) begin
                bus.SDout = bus.SDin;
            end else begin
                mc = cyc % 1024;
                mk = (mc / 16) % 32;
                mw = (mc >= 512) ? m_r : m_l;
                if (mk >= 1 && mk <= 16) bus.SDout = mw[16 - mk];
                else                     bus.SDout = 1'b0;
            end
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (bus.valid === 1'b1) n_valid++;
        end
    endtask

    task automatic goto(input int target);
        int guard;
        guard = 0;
        while (cyc < target && guard < 20000) begin
            step(1);
            guard++;
        end
        if (cyc != target) begin
            checks++;
            failures++;
            $display("FAIL goto_bound: reached cycle %0d, required %0d", cyc, target);
        end
    endtask

    task automatic test_reset();
        step(5);
        checks++;
        if ({bus.MCLK, bus.SCLK, bus.LRCLK} !== 3'b000) begin
            failures++;
            $display("FAIL reset_clocks: got %b required 000", {bus.MCLK, bus.SCLK, bus.LRCLK});
        end
        checks++;
        if ({bus.SDin, bus.RSTn, bus.valid} !== 3'b000) begin
            failures++;
            $display("FAIL reset_ctrl: got %b required 000", {bus.SDin, bus.RSTn, bus.valid});
        end
        checks++;
        if ({bus.lft_in, bus.rht_in} !== 32'h0) begin
            failures++;
            $display("FAIL reset_data: got %h required 00000000", {bus.lft_in, bus.rht_in});
        end
        rst = 1'b0;
        n_valid = 0;
    endtask

    task automatic test_clocks();
        int em, es, el;
        logic [9:0] cv;
        em = 0; es = 0; el = 0;
        for (int i = 0; i < 1022; i++) begin
            step(1);
            cv = cyc[9:0];
            if (bus.MCLK  !== cv[1]) em++;
            if (bus.SCLK  !== cv[3]) es++;
            if (bus.LRCLK !== cv[9]) el++;
        end
        checks++;
        if (em !== 0) begin failures++; $display("FAIL clk_mclk: %0d cycles wrong, required 0", em); end
        checks++;
        if (es !== 0) begin failures++; $display("FAIL clk_sclk: %0d cycles wrong, required 0", es); end
        checks++;
        if (el !== 0) begin failures++; $display("FAIL clk_lrclk: %0d cycles wrong, required 0", el); end
    endtask

    task automatic test_startup();
        goto(1023);
        checks++;
        if (bus.RSTn !== 1'b0) begin failures++; $display("FAIL rstn_before_wrap: got %b required 0", bus.RSTn); end
        step(1);
        checks++;
        if (bus.RSTn !== 1'b1) begin failures++; $display("FAIL rstn_after_wrap: got %b required 1", bus.RSTn); end
        checks++;
        if (bus.LRCLK !== 1'b0) begin failures++; $display("FAIL lrclk_fall: got %b required 0", bus.LRCLK); end
        goto(2823);
        checks++;
        if (n_valid !== 0) begin failures++; $display("FAIL early_valid: got %0d pulses required 0", n_valid); end
        step(1);
        checks++;
        if (bus.valid !== 1'b1) begin failures++; $display("FAIL first_valid: got %b required 1", bus.valid); end
        checks++;
        if (bus.lft_in !== 16'hA5C3) begin failures++; $display("FAIL rx_left: got %h required a5c3", bus.lft_in); end
        checks++;
        if (bus.rht_in !== 16'h8001) begin failures++; $display("FAIL rx_right: got %h required 8001", bus.rht_in); end
        step(1);
        checks++;
        if (bus.valid !== 1'b0) begin failures++; $display("FAIL valid_width: got %b required 0", bus.valid); end
    endtask

    task automatic test_receive_hold();
        m_l = 16'h0F0F;
        m_r = 16'hFFFF;
        n_valid = 0;
        goto(3847);
        checks++;
        if (n_valid !== 0 || bus.lft_in !== 16'hA5C3 || bus.rht_in !== 16'h8001) begin
            failures++;
            $display("FAIL rx_hold: got pulses=%0d L=%h R=%h required 0 a5c3 8001", n_valid, bus.lft_in, bus.rht_in);
        end
        step(1);
        checks++;
        if (bus.valid !== 1'b1 || bus.lft_in !== 16'h0F0F || bus.rht_in !== 16'hFFFF) begin
            failures++;
            $display("FAIL rx_second: got v=%b L=%h R=%h required 1 0f0f ffff", bus.valid, bus.lft_in, bus.rht_in);
        end
    endtask

    task automatic test_transmit();
        logic [15:0] wl, wr;
        logic [9:0]  cv;
        logic        held;
        int          k, zerr, serr;
        wl = '0; wr = '0; held = 1'b0; zerr = 0; serr = 0;
        goto(4095);
        for (int i = 0; i < 1024; i++) begin
            step(1);
            cv = cyc[9:0];
            k  = int'(cv[8:4]);
            if (cv[3:0] == 4'd8) begin
                held = bus.SDin;
                if (k >= 1 && k <= 16) begin
                    if (cv[9]) wr[16 - k] = bus.SDin;
                    else       wl[16 - k] = bus.SDin;
                end else if (bus.SDin !== 1'b0) begin
                    zerr++;
                end
            end else if (cv[3:0] > 4'd8 && bus.SDin !== held) begin
                serr++;
            end
        end
        checks++;
        if (wl !== 16'h7FFF) begin failures++; $display("FAIL tx_left: got %h required 7fff", wl); end
        checks++;
        if (wr !== 16'h8000) begin failures++; $display("FAIL tx_right: got %h required 8000", wr); end
        checks++;
        if (zerr !== 0) begin failures++; $display("FAIL tx_idle_zero: %0d slots nonzero, required 0", zerr); end
        checks++;
        if (serr !== 0) begin failures++; $display("FAIL tx_stable: %0d glitches, required 0", serr); end
    endtask

    task automatic test_loopback();
        loopback    = 1'b1;
        bus.lft_out = 16'h1234;
        bus.rht_out = 16'h00FF;
        goto(5220);
        bus.lft_out = 16'hDEAD;
        goto(5896);
        checks++;
        if (bus.valid !== 1'b1 || bus.lft_in !== 16'h1234 || bus.rht_in !== 16'h00FF) begin
            failures++;
            $display("FAIL loop_first: got v=%b L=%h R=%h required 1 1234 00ff", bus.valid, bus.lft_in, bus.rht_in);
        end
        goto(6920);
        checks++;
        if (bus.lft_in !== 16'hDEAD || bus.rht_in !== 16'h00FF) begin
            failures++;
            $display("FAIL loop_next: got L=%h R=%h required dead 00ff", bus.lft_in, bus.rht_in);
        end
    endtask

    task automatic test_midreset();
        loopback = 1'b0;
        m_l = 16'h3C5A;
        m_r = 16'hC3A5;
        goto(7 * 1024 + 600);
        checks++;
        if (bus.RSTn !== 1'b1 || bus.LRCLK !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset: got RSTn=%b LRCLK=%b required 1 1", bus.RSTn, bus.LRCLK);
        end
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        checks++;
        if ({bus.RSTn, bus.SDin, bus.LRCLK, bus.valid} !== 4'b0000) begin
            failures++;
            $display("FAIL mid_reset_ctrl: got %b required 0000", {bus.RSTn, bus.SDin, bus.LRCLK, bus.valid});
        end
        checks++;
        if ({bus.lft_in, bus.rht_in} !== 32'h0) begin
            failures++;
            $display("FAIL mid_reset_data: got %h required 00000000", {bus.lft_in, bus.rht_in});
        end
        n_valid = 0;
        goto(1024);
        checks++;
        if (bus.RSTn !== 1'b1) begin failures++; $display("FAIL re_rstn: got %b required 1", bus.RSTn); end
        goto(2823);
        checks++;
        if (n_valid !== 0 || bus.lft_in !== 16'h0) begin
            failures++;
            $display("FAIL re_early_valid: got pulses=%0d L=%h required 0 0000", n_valid, bus.lft_in);
        end
        step(1);
        checks++;
        if (bus.valid !== 1'b1 || bus.lft_in !== 16'h3C5A || bus.rht_in !== 16'hC3A5) begin
            failures++;
            $display("FAIL re_first_valid: got v=%b L=%h R=%h required 1 3c5a c3a5", bus.valid, bus.lft_in, bus.rht_in);
        end
    endtask

    initial begin
        bus.lft_out = 16'h7FFF;
        bus.rht_out = 16'h8000;
        test_reset();
        test_clocks();
        test_startup();
        test_receive_hold();
        test_transmit();
        test_loopback();
        test_midreset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
